// File: rtl/i3c_ctrlreg_bank_pkg.sv
// ============================================================================
// Module : i3c_ctrlreg_pkg
// Brief  : Register offsets, bit indices and command-state type shared by the
//          I3C master CSR bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i3c_ctrlreg_pkg;

  localparam logic [7:0] c_ADDR_CTRL   = 8'h00;
  localparam logic [7:0] c_ADDR_CMD    = 8'h04;
  localparam logic [7:0] c_ADDR_STATUS = 8'h08;
  localparam logic [7:0] c_ADDR_MASK   = 8'h0C;
  localparam logic [7:0] c_ADDR_PRESC  = 8'h10;

  localparam int c_CTRL_CORE_EN  = 0;
  localparam int c_CTRL_ACK_EN   = 1;
  localparam int c_CTRL_INT_EN   = 2;
  localparam int c_CTRL_SOFT_RST = 31;

  localparam int c_CMD_START = 0;
  localparam int c_CMD_STOP  = 1;

  localparam int c_STAT_BUSY = 16;
  localparam int c_STAT_OVF  = 17;
  localparam int c_STAT_DIS  = 18;

  typedef enum logic [0:0] {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

endpackage

`default_nettype wire

// File: rtl/i3c_ctrlreg_bank_if.sv
// ============================================================================
// Module : i3c_ctrlreg_bank_if
// Brief  : CPU register-port bundle between a bus master and the CSR bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface i3c_ctrlreg_bank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              i_cpu_wr_en;
  logic              i_cpu_rd_en;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_rvalid;
  logic              o_cpu_err;

  modport master (
    output i_cpu_addr, i_cpu_wdata, i_cpu_wr_en, i_cpu_rd_en,
    input  o_cpu_rdata, o_cpu_rvalid, o_cpu_err
  );

  modport slave (
    input  i_cpu_addr, i_cpu_wdata, i_cpu_wr_en, i_cpu_rd_en,
    output o_cpu_rdata, o_cpu_rvalid, o_cpu_err
  );
endinterface

`default_nettype wire

// File: rtl/i3c_ctrlreg_bank_sticky_w1c.sv
// ============================================================================
// Module : i3c_sticky_w1c
// Brief  : Array of sticky event bits, write-1-to-clear, set wins over clear;
//          i_clr_all wipes the whole array synchronously.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i3c_sticky_w1c #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr_all,
  input  logic [W-1:0] i_set,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_all) begin
      r_q <= '0;
    end else begin
      r_q <= (r_q & ~i_clr) | i_set;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/i3c_ctrlreg_bank.sv
// ============================================================================
// Module : i3c_ctrlreg_bank
// Brief  : CPU-facing CSR bank for the I3C master: control, command handshake,
//          sticky event status, masked interrupt and registered read-back.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i3c_ctrlreg_bank
  import i3c_ctrlreg_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 8,
  parameter int                 NUM_EVT   = 8,
  parameter int                 PRESC_W   = 16,
  parameter logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(124)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  i3c_ctrlreg_bank_if.slave  cpu,
  output logic               o_core_en,
  output logic               o_ack_en,
  output logic [PRESC_W-1:0] o_prescale,
  output logic               o_soft_rst,
  output logic               o_cmd_valid,
  output logic               o_cmd_start,
  output logic               o_cmd_stop,
  input  logic               i_cmd_ready,
  input  logic [NUM_EVT-1:0] i_evt,
  output logic               o_irq
);

  // Sticky vector layout: {CMD_DIS, CMD_OVF, EVT[NUM_EVT-1:0]}
  localparam int SW = NUM_EVT + 2;

  logic [ADDR_W-3:0] w_word;
  logic              w_sel_ctrl, w_sel_cmd, w_sel_status, w_sel_mask, w_sel_presc;
  logic              w_mapped, w_wr, w_rd;
  logic [DATA_W-1:0] w_wd;
  logic              w_soft, w_cmd_wr;
  logic [SW-1:0]     w_set, w_clr, w_status;
  logic [DATA_W-1:0] w_rd_mux;
  logic              w_unused;

  logic               r_core_en, r_ack_en, r_int_en, r_soft_rst;
  logic [SW-1:0]      r_mask;
  logic [PRESC_W-1:0] r_prescale;
  cmd_state_e         r_state;
  logic               r_start, r_stop;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid, r_err, r_irq;

  assign w_word       = cpu.i_cpu_addr[ADDR_W-1:2];
  assign w_sel_ctrl   = (w_word == (ADDR_W-2)'(c_ADDR_CTRL   >> 2));
  assign w_sel_cmd    = (w_word == (ADDR_W-2)'(c_ADDR_CMD    >> 2));
  assign w_sel_status = (w_word == (ADDR_W-2)'(c_ADDR_STATUS >> 2));
  assign w_sel_mask   = (w_word == (ADDR_W-2)'(c_ADDR_MASK   >> 2));
  assign w_sel_presc  = (w_word == (ADDR_W-2)'(c_ADDR_PRESC  >> 2));
  assign w_mapped     = w_sel_ctrl | w_sel_cmd | w_sel_status | w_sel_mask | w_sel_presc;
  assign w_wr         = cpu.i_cpu_wr_en;
  assign w_rd         = cpu.i_cpu_rd_en;
  assign w_wd         = cpu.i_cpu_wdata;
  assign w_unused     = ^{cpu.i_cpu_addr[1:0], w_wd};

  assign w_soft   = w_wr & w_sel_ctrl & w_wd[c_CTRL_SOFT_RST];
  assign w_cmd_wr = w_wr & w_sel_cmd & (w_wd[c_CMD_START] | w_wd[c_CMD_STOP]);

  // A write landing in PEND (accept cycle included) is an overflow, never queued.
  assign w_set = {w_cmd_wr & (r_state == CMD_IDLE) & ~r_core_en,
                  w_cmd_wr & (r_state == CMD_PEND),
                  i_evt};
  assign w_clr = (w_wr & w_sel_status)
               ? {w_wd[c_STAT_DIS], w_wd[c_STAT_OVF], w_wd[NUM_EVT-1:0]} : '0;

  i3c_sticky_w1c #(.W(SW)) u_status (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr_all (w_soft),
    .i_set     (w_set),
    .i_clr     (w_clr),
    .o_q       (w_status)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_en  <= 1'b0;
      r_ack_en   <= 1'b0;
      r_int_en   <= 1'b0;
      r_soft_rst <= 1'b0;
      r_mask     <= '0;
      r_prescale <= PRESC_RST;
    end else begin
      r_soft_rst <= w_soft;
      if (w_wr && w_sel_ctrl) begin
        r_core_en <= w_wd[c_CTRL_CORE_EN];
        r_ack_en  <= w_wd[c_CTRL_ACK_EN];
        r_int_en  <= w_wd[c_CTRL_INT_EN];
      end
      if (w_wr && w_sel_mask) begin
        r_mask <= {w_wd[c_STAT_DIS], w_wd[c_STAT_OVF], w_wd[NUM_EVT-1:0]};
      end
      if (w_wr && w_sel_presc) begin
        r_prescale <= w_wd[PRESC_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_soft) begin
      r_state <= CMD_IDLE;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      unique case (r_state)
        CMD_IDLE: begin
          if (w_cmd_wr && r_core_en) begin
            r_state <= CMD_PEND;
            r_start <= w_wd[c_CMD_START];
            r_stop  <= w_wd[c_CMD_STOP];
          end
        end
        CMD_PEND: begin
          if (i_cmd_ready) begin
            r_state <= CMD_IDLE;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
          end
        end
        default: r_state <= CMD_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_sel_ctrl) begin
      w_rd_mux[c_CTRL_CORE_EN] = r_core_en;
      w_rd_mux[c_CTRL_ACK_EN]  = r_ack_en;
      w_rd_mux[c_CTRL_INT_EN]  = r_int_en;
    end else if (w_sel_status) begin
      w_rd_mux[NUM_EVT-1:0] = w_status[NUM_EVT-1:0];
      w_rd_mux[c_STAT_BUSY] = (r_state == CMD_PEND);
      w_rd_mux[c_STAT_OVF]  = w_status[NUM_EVT];
      w_rd_mux[c_STAT_DIS]  = w_status[NUM_EVT+1];
    end else if (w_sel_mask) begin
      w_rd_mux[NUM_EVT-1:0] = r_mask[NUM_EVT-1:0];
      w_rd_mux[c_STAT_OVF]  = r_mask[NUM_EVT];
      w_rd_mux[c_STAT_DIS]  = r_mask[NUM_EVT+1];
    end else if (w_sel_presc) begin
      w_rd_mux[PRESC_W-1:0] = r_prescale;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rdata  <= w_rd ? w_rd_mux : '0;
      r_rvalid <= w_rd;
      r_err    <= (w_rd | w_wr) & ~w_mapped;
      r_irq    <= r_int_en & (|(w_status & r_mask));
    end
  end

  assign cpu.o_cpu_rdata  = r_rdata;
  assign cpu.o_cpu_rvalid = r_rvalid;
  assign cpu.o_cpu_err    = r_err;
  assign o_core_en        = r_core_en;
  assign o_ack_en         = r_ack_en;
  assign o_prescale       = r_prescale;
  assign o_soft_rst       = r_soft_rst;
  assign o_cmd_valid      = (r_state == CMD_PEND);
  assign o_cmd_start      = r_start;
  assign o_cmd_stop       = r_stop;
  assign o_irq            = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_i3c_ctrlreg_bank.sv
// ============================================================================
// Module : tb_i3c_ctrlreg_bank
// Brief  : Scoreboarded bench for the I3C CSR bank: directed scenarios then
//          randomized traffic against a register-map level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i3c_ctrlreg_bank;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int NUM_EVT = 8;
  localparam int PRESC_W = 16;
  localparam logic [31:0] c_W1C = ((32'd1 << NUM_EVT) - 32'd1) | (32'd1 << 17) | (32'd1 << 18);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               cmd_ready;
  logic [NUM_EVT-1:0] evt;
  logic               core_en, ack_en, soft_rst, cmd_valid, cmd_start, cmd_stop, irq;
  logic [PRESC_W-1:0] prescale;

  i3c_ctrlreg_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

  i3c_ctrlreg_bank #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_EVT (NUM_EVT), .PRESC_W (PRESC_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .cpu         (cpu_if),
    .o_core_en   (core_en),
    .o_ack_en    (ack_en),
    .o_prescale  (prescale),
    .o_soft_rst  (soft_rst),
    .o_cmd_valid (cmd_valid),
    .o_cmd_start (cmd_start),
    .o_cmd_stop  (cmd_stop),
    .i_cmd_ready (cmd_ready),
    .i_evt       (evt),
    .o_irq       (irq)
  );

  // Reference model: register contents at map level plus expected registered outputs.
  bit          m_core, m_ack, m_inten, m_pend, m_start, m_stop;
  bit          m_soft, m_irq, m_err, m_rvalid;
  logic [31:0] m_stat, m_mask, m_presc;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;
  rd_exp_t rq[$];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_value(input int word);
    case (word)
      0: return {29'd0, m_inten, m_ack, m_core};
      2: return m_stat | (m_pend ? 32'h0001_0000 : 32'h0);
      3: return m_mask;
      4: return m_presc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_core = 0; m_ack = 0; m_inten = 0; m_pend = 0; m_start = 0; m_stop = 0;
    m_soft = 0; m_irq = 0; m_err = 0; m_rvalid = 0;
    m_stat = 0; m_mask = 0; m_presc = 32'd124;
  endtask

  // Applies one clock edge worth of register-map rules to the model.
  task automatic model_update();
    int          word;
    bit          wr, rd, cw;
    logic [31:0] wd, set, stat_n;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    word = int'(cpu_if.i_cpu_addr) / 4;
    wr   = cpu_if.i_cpu_wr_en;
    rd   = cpu_if.i_cpu_rd_en;
    wd   = cpu_if.i_cpu_wdata;
    if (rd) rq.push_back('{data: reg_value(word), cyc: cyc});
    m_rvalid = rd;
    m_err    = (rd || wr) && word > 4;
    m_irq    = m_inten && ((m_stat & m_mask) != 0);
    m_soft   = wr && word == 0 && wd[31];
    cw       = wr && word == 1 && wd[1:0] != 2'b00;
    set      = 32'(evt);
    if (cw && m_pend) set = set | (32'd1 << 17);
    else if (cw && !m_core) set = set | (32'd1 << 18);
    stat_n = (wr && word == 2) ? (m_stat & ~(wd & c_W1C)) : m_stat;
    stat_n = stat_n | set;
    if (m_soft) begin
      stat_n = 0;
      m_pend = 0; m_start = 0; m_stop = 0;
    end else if (m_pend) begin
      if (cmd_ready) begin m_pend = 0; m_start = 0; m_stop = 0; end
    end else if (cw && m_core) begin
      m_pend = 1; m_start = wd[0]; m_stop = wd[1];
    end
    m_stat = stat_n;
    if (wr && word == 0) begin m_core = wd[0]; m_ack = wd[1]; m_inten = wd[2]; end
    if (wr && word == 3) m_mask = wd & c_W1C;
    if (wr && word == 4) m_presc = {16'd0, wd[15:0]};
  endtask

  // Monitor: compares every registered output and pops read expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("core_en", 64'(core_en), 64'(m_core));
      chk("ack_en", 64'(ack_en), 64'(m_ack));
      chk("prescale", 64'(prescale), 64'(m_presc));
      chk("soft_rst", 64'(soft_rst), 64'(m_soft));
      chk("cmd_valid", 64'(cmd_valid), 64'(m_pend));
      chk("cmd_start", 64'(cmd_start), 64'(m_start));
      chk("cmd_stop", 64'(cmd_stop), 64'(m_stop));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("cpu_err", 64'(cpu_if.o_cpu_err), 64'(m_err));
      chk("rvalid", 64'(cpu_if.o_cpu_rvalid), 64'(m_rvalid));
      if (cpu_if.o_cpu_rvalid) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", 64'(1), 64'(0));
        end else begin
          rd_exp_t e;
          e = rq.pop_front();
          chk("rdata", 64'(cpu_if.o_cpu_rdata), 64'(e.data));
          chk("rd_latency", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("rdata_idle", 64'(cpu_if.o_cpu_rdata), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic bus(input bit wr, input bit rd, input logic [7:0] a, input logic [31:0] d);
    cpu_if.i_cpu_addr  = a;
    cpu_if.i_cpu_wdata = d;
    cpu_if.i_cpu_wr_en = wr;
    cpu_if.i_cpu_rd_en = rd;
    step();
    cpu_if.i_cpu_wr_en = 1'b0;
    cpu_if.i_cpu_rd_en = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d); bus(1, 0, a, d); endtask
  task automatic rd_reg(input logic [7:0] a); bus(0, 1, a, 32'h0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(); endtask

  initial begin
    cpu_if.i_cpu_addr = '0; cpu_if.i_cpu_wdata = '0;
    cpu_if.i_cpu_wr_en = 0; cpu_if.i_cpu_rd_en = 0;
    cmd_ready = 0; evt = '0; rst = 1;
    model_reset();
    step();
    mon_en = 1'b1;
    step();
    rst = 0;

    // Reset values of every register
    rd_reg(8'h00); rd_reg(8'h04); rd_reg(8'h08); rd_reg(8'h0C); rd_reg(8'h10);

    // Command held pending while the core is not ready, then overflow and accept
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h04, 32'h3);
    idle(4);
    rd_reg(8'h08);
    wr_reg(8'h04, 32'h1);
    rd_reg(8'h09);
    cmd_ready = 1; step(); cmd_ready = 0;
    idle(1);

    // Write in the accept cycle is an overflow too
    wr_reg(8'h04, 32'h2);
    cmd_ready = 1; wr_reg(8'h04, 32'h1); cmd_ready = 0;
    idle(1);
    wr_reg(8'h04, 32'h0);
    rd_reg(8'h08);

    // Command while disabled
    wr_reg(8'h00, 32'h0);
    wr_reg(8'h04, 32'h1);
    rd_reg(8'h08);
    wr_reg(8'h08, 32'h0006_0000);
    rd_reg(8'h08);

    // Masked event interrupt, set-wins, then clear
    wr_reg(8'h0C, 32'h1);
    wr_reg(8'h00, 32'h5);
    evt = 8'h01; step(); evt = '0;
    idle(2);
    rd_reg(8'h08);
    evt = 8'h01; wr_reg(8'h08, 32'h1); evt = '0;
    rd_reg(8'h08);
    wr_reg(8'h08, 32'h1);
    idle(2);

    // Soft reset while a command is pending
    wr_reg(8'h00, 32'h1);
    wr_reg(8'h04, 32'h3);
    wr_reg(8'h00, 32'h8000_0001);
    idle(1);
    rd_reg(8'h00); rd_reg(8'h08);

    // Unmapped accesses and read-before-write on the same address
    rd_reg(8'h20);
    wr_reg(8'h20, 32'hFFFF_FFFF);
    bus(1, 1, 8'h10, 32'h0000_0055);
    rd_reg(8'h13);

    // Reset while pending
    wr_reg(8'h04, 32'h2);
    rst = 1; step(); rst = 0;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int          r, w;
      logic [31:0] d;
      r = int'($urandom_range(0, 9));
      w = int'($urandom_range(0, 6));
      if (w == 5) w = 8;
      if (w == 6) w = 5;
      d = $urandom;
      if (w == 0) begin
        d[31] = ($urandom_range(0, 7) == 0);
        d[0]  = ($urandom_range(0, 3) != 0);
      end
      cpu_if.i_cpu_addr  = 8'(w * 4 + int'($urandom_range(0, 3)));
      cpu_if.i_cpu_wdata = d;
      cpu_if.i_cpu_wr_en = (r < 3);
      cpu_if.i_cpu_rd_en = (r >= 2 && r < 6);
      evt       = ($urandom_range(0, 3) == 0) ? NUM_EVT'($urandom) : '0;
      cmd_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    cpu_if.i_cpu_wr_en = 0; cpu_if.i_cpu_rd_en = 0;
    evt = '0; cmd_ready = 0; rst = 0;
    idle(3);
    chk("rd_queue_drained", 64'(rq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
